ram_dma_engine: RTL and testbench

Byte-wide copy/fill engine that drives the host-side port of the 32 KB synchronous single-port RAM block (15-bit address, write enable, 8-bit write data, 8-bit read data valid one edge after address). It is the initiator on that memory interface. It sits between the control/register logic and the RAM, and moves or initialises memory blocks without CPU involvement. The CPU path is muxed off the RAM port while `busy` is high. That mux is outside this block.

---
 rtl/ram_dma_pkg.sv | 30 +++
 rtl/ram_dma_engine_if.sv | 28 ++
 rtl/ram_dma_engine.sv | 105 ++++++++++
 tb/tb_ram_dma_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM copy/fill DMA engine.
package ram_dma_pkg;

    localparam int unsigned RAM_ADDR_W = 15;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_BYTES  = 32768;
    localparam int unsigned LEN_W      = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FILL  = 2'd3
    } state_t;

    // One RAM write beat: address plus data byte.
    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] data;
    } ram_wr_t;

    // A request longer than the RAM is clipped to one full pass of the address space.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(RAM_BYTES)) ? LEN_W'(RAM_BYTES) : len;
    endfunction

endpackage

// File: rtl/ram_dma_engine_if.sv
// Control and RAM host-port signals of the DMA engine, bundled with engine/peer modports.
interface ram_dma_engine_if;
    import ram_dma_pkg::*;

    logic                  start;
    logic                  mode;
    logic [RAM_ADDR_W-1:0] src_addr;
    logic [RAM_ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]      length;
    logic [RAM_DATA_W-1:0] fill_value;
    logic                  busy;
    logic                  done;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  ram_write_enable;
    logic [RAM_DATA_W-1:0] ram_data_in;
    logic [RAM_DATA_W-1:0] ram_data_out;

    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_value, ram_data_out,
        output busy, done, ram_addr, ram_write_enable, ram_data_in
    );

    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_value, ram_data_out,
        input  busy, done, ram_addr, ram_write_enable, ram_data_in
    );

endinterface

// File: rtl/ram_dma_engine.sv
// Byte-wide copy/fill engine driving the host port of the 32 KB single-port RAM.
module ram_dma_engine
    import ram_dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ram_dma_engine_if.master bus
);

    state_t                state, state_next;
    logic [RAM_ADDR_W-1:0] src_ptr;
    logic [RAM_ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]      remaining;
    logic [RAM_DATA_W-1:0] fill_byte;
    logic                  done_q;
    logic [LEN_W-1:0]      len_eff_c;
    logic                  last_c;

    assign len_eff_c = eff_len(bus.length);
    assign last_c    = (remaining == LEN_W'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start && (len_eff_c != '0)) begin
                    state_next = (bus.mode == MODE_FILL) ? FILL : READ;
                end
            end
            READ:    state_next = WRITE;
            WRITE:   state_next = last_c ? IDLE : READ;
            FILL:    state_next = last_c ? IDLE : FILL;
            default: state_next = IDLE;
        endcase
    end

    // RAM port decode from state flops; write data in WRITE is the byte read on the previous edge
    always_comb begin
        bus.ram_addr         = '0;
        bus.ram_write_enable = 1'b0;
        bus.ram_data_in      = '0;
        case (state)
            READ: begin
                bus.ram_addr = src_ptr;
            end
            WRITE: begin
                bus.ram_addr         = dst_ptr;
                bus.ram_write_enable = 1'b1;
                bus.ram_data_in      = bus.ram_data_out;
            end
            FILL: begin
                bus.ram_addr         = dst_ptr;
                bus.ram_write_enable = 1'b1;
                bus.ram_data_in      = fill_byte;
            end
            default: ;
        endcase
        bus.busy = (state != IDLE);
        bus.done = done_q;
    end

    // Operand latch, pointers, down-counter and completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            fill_byte <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_ptr   <= bus.src_addr;
                        dst_ptr   <= bus.dst_addr;
                        remaining <= len_eff_c;
                        fill_byte <= bus.fill_value;
                        done_q    <= (len_eff_c == '0);
                    end
                end
                READ: begin
                    src_ptr <= src_ptr + RAM_ADDR_W'(1);
                end
                WRITE, FILL: begin
                    dst_ptr   <= dst_ptr + RAM_ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
                    done_q    <= last_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine against a behavioural 32 KB RAM with a write scoreboard.
module tb_ram_dma_engine;
    import ram_dma_pkg::*;

    logic clk;
    logic reset;

    ram_dma_engine_if bus ();

    ram_dma_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem   [32768];
    logic [7:0] model [32768];
    ram_wr_t    exp_q [$];

    int errors   = 0;
    int checks   = 0;
    int wr_count = 0;
    int done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data_out is the old content of the address presented at the edge
    always @(posedge clk) begin
        if (bus.ram_write_enable === 1'b1) mem[bus.ram_addr] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle: every write beat must match the scoreboard head
    always @(negedge clk) begin
        ram_wr_t e;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.ram_write_enable === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
                check("wr_data", 32'(bus.ram_data_in), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        mem[a]   = d;
        model[a] = d;
    endtask

    task automatic run_xfer(input logic m, input logic [14:0] s, input logic [14:0] d,
                            input logic [15:0] len, input logic [7:0] fv,
                            input bit poke, input string tag);
        int      neff;
        int      n;
        int      d0;
        int      w0;
        ram_wr_t e;
        neff = (len > 16'd32768) ? 32768 : int'(len);
        for (int i = 0; i < neff; i++) begin
            e.addr = 15'(d + 15'(i));
            e.data = m ? fv : model[15'(s + 15'(i))];
            model[e.addr] = e.data;
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        w0 = wr_count;
        bus.mode       = m;
        bus.src_addr   = s;
        bus.dst_addr   = d;
        bus.length     = len;
        bus.fill_value = fv;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 70000) begin
            if (poke && n == 2) begin
                bus.mode       = MODE_FILL;
                bus.dst_addr   = 15'h0400;
                bus.length     = 16'd2;
                bus.fill_value = 8'h11;
                bus.start      = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            n++;
            tick();
        end
        bus.start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), m ? 32'(neff) : 32'(2 * neff));
        check({tag, "_done_high"}, 32'(bus.done), 32'd1);
        tick();
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_write_count"}, 32'(wr_count - w0), 32'(neff));
        check({tag, "_scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ram_wr_t e;
        int      d0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.length     = '0;
        bus.fill_value = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]   = 8'(i) ^ 8'h5C;
            model[i] = 8'(i) ^ 8'h5C;
        end
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_we", 32'(bus.ram_write_enable), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_din", 32'(bus.ram_data_in), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic fill
        run_xfer(MODE_FILL, 15'h0000, 15'h0100, 16'd4, 8'hA5, 1'b0, "fill4");
        for (int i = 0; i < 4; i++) check("fill4_readback", 32'(mem[15'h0100 + 15'(i)]), 32'hA5);
        check("fill4_untouched", 32'(mem[15'h0104]), 32'(8'h04 ^ 8'h5C));

        // Basic copy
        preload(15'h0000, 8'h11);
        preload(15'h0001, 8'h22);
        preload(15'h0002, 8'h33);
        run_xfer(MODE_COPY, 15'h0000, 15'h2000, 16'd3, 8'h00, 1'b0, "copy3");
        check("copy3_b0", 32'(mem[15'h2000]), 32'h11);
        check("copy3_b1", 32'(mem[15'h2001]), 32'h22);
        check("copy3_b2", 32'(mem[15'h2002]), 32'h33);

        // Fill across the top of the address space
        run_xfer(MODE_FILL, 15'h0000, 15'h7FFE, 16'd4, 8'h3C, 1'b0, "fill_wrap");
        check("wrap_7ffe", 32'(mem[15'h7FFE]), 32'h3C);
        check("wrap_0001", 32'(mem[15'h0001]), 32'h3C);
        check("wrap_7ffd", 32'(mem[15'h7FFD]), 32'(model[15'h7FFD]));

        // Overlapping copy replicates the source byte
        preload(15'h0010, 8'h5A);
        run_xfer(MODE_COPY, 15'h0010, 15'h0011, 16'd3, 8'h00, 1'b0, "copy_ovl");
        for (int i = 1; i < 4; i++) check("ovl_readback", 32'(mem[15'h0010 + 15'(i)]), 32'h5A);

        // Zero length: done only
        run_xfer(MODE_FILL, 15'h0000, 15'h0500, 16'd0, 8'hFF, 1'b0, "len0");
        run_xfer(MODE_COPY, 15'h0000, 15'h0500, 16'd0, 8'hFF, 1'b0, "len0_copy");

        // start while busy is ignored
        run_xfer(MODE_FILL, 15'h0000, 15'h0300, 16'd8, 8'h77, 1'b1, "poke");
        check("poke_ignored_0400", 32'(mem[15'h0400]), 32'(model[15'h0400]));
        check("poke_last_byte", 32'(mem[15'h0307]), 32'h77);

        // Reset in the second WRITE cycle of a 4-byte copy: only byte 0 lands
        for (int i = 0; i < 4; i++) preload(15'h0040 + 15'(i), 8'hD1 + 8'(i));
        e.addr = 15'h0050;
        e.data = 8'hD1;
        model[e.addr] = e.data;
        exp_q.push_back(e);
        d0 = done_cnt;
        bus.mode     = MODE_COPY;
        bus.src_addr = 15'h0040;
        bus.dst_addr = 15'h0050;
        bus.length   = 16'd4;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("rstmid_in_write", 32'(bus.ram_write_enable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_we_low", 32'(bus.ram_write_enable), 32'd0);
        check("rstmid_busy_low", 32'(bus.busy), 32'd0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rstmid_scoreboard", 32'(exp_q.size()), 32'd0);
        check("rstmid_byte0", 32'(mem[15'h0050]), 32'hD1);
        check("rstmid_byte1_untouched", 32'(mem[15'h0051]), 32'(8'h51 ^ 8'h5C));
        run_xfer(MODE_COPY, 15'h0040, 15'h0060, 16'd4, 8'h00, 1'b0, "after_rst");
        check("after_rst_b3", 32'(mem[15'h0063]), 32'hD4);

        // Oversized fill clips to one full pass
        run_xfer(MODE_FILL, 15'h0000, 15'h1234, 16'hFFFF, 8'hE7, 1'b0, "fill_max");
        check("fill_max_0000", 32'(mem[15'h0000]), 32'hE7);
        check("fill_max_1233", 32'(mem[15'h1233]), 32'hE7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
